// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the iterative RV64M multiplier.
// Op encodings match the i_op field driven by the decode stage.
package mul_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_MULW   = 3'b100
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADJUST,
    ST_DONE
  } mul_state_t;

  localparam int unsigned MUL_ITER_FULL = 64;
  localparam int unsigned MUL_ITER_W    = 32;
  localparam int unsigned MUL_CNT_W     = 7;

  // Unused encodings (101..111) behave as a plain MUL.
  function automatic mul_op_t decode_op(input logic [2:0] raw);
    mul_op_t op;
    case (raw)
      3'b001:  op = OP_MULH;
      3'b010:  op = OP_MULHSU;
      3'b011:  op = OP_MULHU;
      3'b100:  op = OP_MULW;
      default: op = OP_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// Works on operand magnitudes and fixes the sign of the 128-bit product at the end.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = MUL_CNT_W;

  mul_state_t      state_q,  state_d;
  mul_op_t         op_q,     op_d;
  logic [PW-1:0]   mcand_q,  mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]   acc_q,    acc_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            neg_q,    neg_d;
  logic [DW-1:0]   result_q, result_d;

  mul_op_t         op_in;
  logic            signed_a, signed_b;
  logic            sign_a,   sign_b;
  logic [DW-1:0]   a_src,    b_src;
  logic [DW-1:0]   mag_a,    mag_b;
  logic [PW-1:0]   product;

  // MULW sign-extends the low words first so the same magnitude path serves all ops.
  always_comb begin
    op_in    = decode_op(i_op);
    a_src    = i_rs1;
    b_src    = i_rs2;
    signed_a = 1'b1;
    signed_b = 1'b1;
    case (op_in)
      OP_MULHSU: signed_b = 1'b0;
      OP_MULHU: begin
        signed_a = 1'b0;
        signed_b = 1'b0;
      end
      OP_MULW: begin
        a_src = {{(DW-32){i_rs1[31]}}, i_rs1[31:0]};
        b_src = {{(DW-32){i_rs2[31]}}, i_rs2[31:0]};
      end
      default: ;
    endcase
    sign_a = signed_a & a_src[DW-1];
    sign_b = signed_b & b_src[DW-1];
    mag_a  = sign_a ? (~a_src + DW'(1)) : a_src;
    mag_b  = sign_b ? (~b_src + DW'(1)) : b_src;
  end

  assign product = neg_q ? (~acc_q + PW'(1)) : acc_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d     = op_in;
          mcand_d  = {{DW{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          neg_d    = sign_a ^ sign_b;
          cnt_d    = (op_in == OP_MULW) ? CW'(MUL_ITER_W) : CW'(MUL_ITER_FULL);
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_ADJUST;
        end
      end
      ST_ADJUST: begin
        case (op_q)
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = product[PW-1:DW];
          OP_MULW:                      result_d = {{(DW-32){product[31]}}, product[31:0]};
          default:                      result_d = product[DW-1:0];
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases, protocol checks
// and randomized ops compared against a plain-arithmetic 128-bit reference.
module tb_mul_unit;

  logic        clk;
  logic        rstn;
  logic        i_start;
  logic [2:0]  i_op;
  logic [63:0] i_rs1;
  logic [63:0] i_rs2;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_result;

  int n_cmp = 0;
  int n_err = 0;

  mul_unit #(.DATA_WIDTH(64)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: signed/unsigned extension to 128 bits, then one full multiply.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    case (op)
      3'd2: begin
        ea = {{64{a[63]}}, a};
        eb = {64'd0, b};
      end
      3'd3: begin
        ea = {64'd0, a};
        eb = {64'd0, b};
      end
      3'd4: begin
        ea = {{96{a[31]}}, a[31:0]};
        eb = {{96{b[31]}}, b[31:0]};
      end
      default: begin
        ea = {{64{a[63]}}, a};
        eb = {{64{b[63]}}, b};
      end
    endcase
    p = ea * eb;
    case (op)
      3'd1, 3'd2, 3'd3: return p[127:64];
      3'd4:             return {{32{p[31]}}, p[31:0]};
      default:          return p[63:0];
    endcase
  endfunction

  function automatic int latency_for(input logic [2:0] op);
    return (op == 3'd4) ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {$urandom, 32'h8000_0000};
      5:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, lets the acceptance edge pass, then scrambles the inputs.
  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    i_start = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    step();
    i_start = 1'b0;
    i_op    = 3'($urandom);
    i_rs1   = {$urandom, $urandom};
    i_rs2   = {$urandom, $urandom};
  endtask

  task automatic waitDone(inout int cycles);
    while (!o_done && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] expected);
    int cyc;
    cyc = 0;
    applyStimulus(op, a, b);
    checkOutput({tag, "_busy"}, 64'(o_busy), 64'd1);
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(latency_for(op)));
    checkOutput({tag, "_result"}, o_result, expected);
    checkOutput({tag, "_busy_in_done"}, 64'(o_busy), 64'd1);
    step();
    checkOutput({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    checkOutput({tag, "_idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [2:0]  op;
    logic [63:0] a, b;

    rstn    = 1'b0;
    i_start = 1'b0;
    i_op    = 3'd0;
    i_rs1   = 64'd0;
    i_rs2   = 64'd0;
    step();
    step();
    checkOutput("reset_busy", 64'(o_busy), 64'd0);
    checkOutput("reset_done", 64'(o_done), 64'd0);
    checkOutput("reset_result", o_result, 64'd0);
    rstn = 1'b1;
    step();

    runOp("mul_3x-5", 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp("mulhu_ones", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("mulhsu_ones", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("mulh_minneg", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
    runOp("mulw_ovf", 3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("op_unused", 3'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7);

    // A start pulse mid-operation carrying other operands must be ignored.
    cyc = 0;
    applyStimulus(3'd0, 64'd6, 64'd7);
    repeat (9) begin
      step();
      cyc++;
    end
    i_start = 1'b1;
    i_op    = 3'd3;
    i_rs1   = 64'hDEAD_BEEF_0000_1234;
    i_rs2   = 64'h1111_2222_3333_4444;
    step();
    cyc++;
    i_start = 1'b0;
    waitDone(cyc);
    checkOutput("busy_start_latency", 64'(cyc), 64'd65);
    checkOutput("busy_start_result", o_result, 64'h2A);

    // Start raised during DONE is only taken on the following IDLE cycle.
    i_start = 1'b1;
    i_op    = 3'd0;
    i_rs1   = 64'd2;
    i_rs2   = 64'd3;
    step();
    checkOutput("done_start_not_taken", 64'(o_busy), 64'd0);
    checkOutput("done_start_result_held", o_result, 64'h2A);
    step();
    i_start = 1'b0;
    checkOutput("idle_start_taken", 64'(o_busy), 64'd1);
    cyc = 0;
    waitDone(cyc);
    checkOutput("idle_start_latency", 64'(cyc), 64'd65);
    checkOutput("idle_start_result", o_result, 64'd6);
    step();

    // Reset mid-operation aborts without a done pulse.
    applyStimulus(3'd0, 64'd6, 64'd7);
    repeat (19) step();
    rstn = 1'b0;
    step();
    checkOutput("midrst_busy", 64'(o_busy), 64'd0);
    checkOutput("midrst_done", 64'(o_done), 64'd0);
    checkOutput("midrst_result", o_result, 64'd0);
    rstn = 1'b1;
    seen = 0;
    repeat (80) begin
      step();
      if (o_done) seen++;
    end
    checkOutput("midrst_no_done", 64'(seen), 64'd0);
    runOp("after_rst_6x7", 3'd0, 64'd6, 64'd7, 64'h2A);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      runOp("rand", op, a, b, model(op, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
